amo_unit: RTL and testbench

AMO_UNIT -- requirements
Module: amo_unit
Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the data and address width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port is_atomic_mem  input  1  the MEM-stage instruction is LR, SC or AMO.
REQ-005 SHALL have port amo_funct5_mem  input  5  instr[31:27] of the MEM-stage instruction.
REQ-006 SHALL have port addr_mem  input  XLEN  effective address (rs1).
REQ-007 SHALL have port rs2_data_mem  input  XLEN  forwarded rs2 operand.
REQ-008 SHALL have port mem_hold  input  1  MEM stage will not advance this cycle (external stall).
REQ-009 SHALL have port store_mem  input  1  a non-atomic store commits at addr_mem this cycle.
REQ-010 SHALL have port trap  input  1  a trap is taken this cycle.
REQ-011 SHALL have port dmem_req  output  1  data-memory request.
REQ-012 SHALL have port dmem_we  output  1  request is a write.
REQ-013 SHALL have port dmem_addr  output  XLEN  word address of the request.
REQ-014 SHALL have port dmem_wdata  output  XLEN  write data.
REQ-015 SHALL have port dmem_rdata  input  XLEN  read data, valid when dmem_ack is high.
REQ-016 SHALL have port dmem_ack  input  1  request accepted/completed; may be high in the same cycle as dmem_req.
REQ-017 SHALL have port atomic_unit_stall  output  1  freezes the pipeline; consumed by the hazard logic.
REQ-018 SHALL have port amo_result  output  XLEN  rd writeback value.
REQ-019 SHALL have port amo_result_valid  output  1  amo_result is final this cycle.
REQ-020 SHALL have port amo_misaligned  output  1  one-cycle misaligned-address exception pulse.
Function
REQ-021 SHALL use FSM states IDLE, RD, WR, DONE.
REQ-022 SHALL assert atomic_unit_stall combinationally in IDLE when is_atomic_mem=1, and in RD and WR; it SHALL be 0 in DONE.
REQ-023 SHALL, in IDLE with is_atomic_mem=1 and addr_mem[1:0]!=0, pulse amo_misaligned, issue no request, and go to DONE.
REQ-024 SHALL, in IDLE, go to RD for LR/AMO ops; for SC it SHALL go to WR if the reservation is valid and matches addr_mem[XLEN-1:2], else to DONE with result 1.
REQ-025 SHALL, in RD, drive req=1, we=0, addr={addr_mem[XLEN-1:2],2'b00}; on ack it SHALL capture rdata as old, then go to DONE (LR, which sets the reservation) or to WR (AMO).
REQ-026 SHALL, in WR, drive req=1, we=1; wdata=rs2 for SWAP/SC, else f(old, rs2); on ack it SHALL go to DONE.
REQ-027 SHALL compute f as follows: ADD 00000 wraps modulo 2^XLEN; SWAP 00001; XOR 00100; OR 01000; AND 01100; MIN 10000 and MAX 10100 compare signed; MINU 11000 and MAXU 11100 compare unsigned.
REQ-028 SHALL, in DONE, drive amo_result_valid=1, with amo_result = old (LR/AMO), 0 (SC success) or 1 (SC fail, or misaligned: 0); it SHALL hold DONE while mem_hold=1 and go to IDLE when mem_hold=0.
REQ-029 SHALL hold dmem_addr, dmem_we and dmem_wdata stable while dmem_req=1 and dmem_ack=0.
REQ-030 SHALL clear the reservation on any SC completion, on trap, and on store_mem to the reserved word; a clear and an LR set in the same cycle SHALL leave the reservation set.
REQ-031 SHALL NOT abort an in-flight RD/WR on trap; the transaction SHALL complete normally.
REQ-032 SHALL treat an unknown funct5 as SWAP.
Reset
REQ-033 SHALL, on reset_n=0, immediately force IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, amo_result=0, amo_result_valid=0, amo_misaligned=0, and reservation invalid, including mid-transaction.
REQ-034 SHALL leave reset on the first rising clk edge after reset_n rises.
Structure
REQ-035 SHALL take amo_state_t and amo_op_t (funct5 encodings) from the shared core package.
REQ-036 SHALL place f in sub-module amo_alu, which is purely combinational.
REQ-037 SHALL be a single FSM plus the reservation register; it SHALL contain no other storage.
Verification
REQ-038 SHALL check AMOADD.W at 0x100 with mem=5, rs2=7 and ack in the same cycle: stall is high for 3 cycles, mem becomes 12, result=5.
REQ-039 SHALL check LR.W 0x200 then SC.W 0x200 with no intervening store: SC writes rs2 and result=0; a second SC gives result=1 with no write.
REQ-040 SHALL check LR 0x200, store_mem to 0x200, then SC 0x200: result=1, with no dmem write.
REQ-041 SHALL check AMOMIN.W with mem=0xFFFFFFFF, rs2=1 -> mem unchanged; AMOMINU.W with the same values -> mem=1.
REQ-042 SHALL check an AMO at 0x102 -> amo_misaligned pulses 1 cycle, dmem_req stays 0.
REQ-043 SHALL check reset_n asserted in WR while ack is withheld: dmem_req=0 immediately, and the state is IDLE after reset_n rises.

---
 rtl/amo_pkg.sv | 27 ++
 rtl/amo_alu.sv | 30 +++
 rtl/amo_unit.sv | 162 ++++++++++++++++
 tb/tb_amo_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/amo_pkg.sv
// Shared core definitions for the atomic memory-operation unit.
package amo_pkg;

  // Sequencer states of the atomic unit.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    DONE = 2'b11
  } amo_state_t;

  // funct5 encodings (instr[31:27]) of the A-extension word operations.
  typedef enum logic [4:0] {
    AMO_ADD  = 5'b00000,
    AMO_SWAP = 5'b00001,
    AMO_LR   = 5'b00010,
    AMO_SC   = 5'b00011,
    AMO_XOR  = 5'b00100,
    AMO_OR   = 5'b01000,
    AMO_AND  = 5'b01100,
    AMO_MIN  = 5'b10000,
    AMO_MAX  = 5'b10100,
    AMO_MINU = 5'b11000,
    AMO_MAXU = 5'b11100
  } amo_op_t;

endpackage

// File: rtl/amo_alu.sv
// Read-modify-write combiner: new memory value from the old value and rs2.
// Any funct5 without a defined combine (including unknown codes) behaves as SWAP.
module amo_alu
  import amo_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      funct5,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] result
);

  // Select the combine function; MIN/MAX are signed, MINU/MAXU unsigned.
  always_comb begin
    result = operand;
    case (funct5)
      AMO_ADD:  result = old_val + operand;
      AMO_XOR:  result = old_val ^ operand;
      AMO_OR:   result = old_val | operand;
      AMO_AND:  result = old_val & operand;
      AMO_MIN:  result = ($signed(old_val) < $signed(operand)) ? old_val : operand;
      AMO_MAX:  result = ($signed(old_val) > $signed(operand)) ? old_val : operand;
      AMO_MINU: result = (old_val < operand) ? old_val : operand;
      AMO_MAXU: result = (old_val > operand) ? old_val : operand;
      default:  result = operand;
    endcase
  end

endmodule

// File: rtl/amo_unit.sv
// Atomic memory-operation sequencer for the MEM stage (LR.W / SC.W / AMO*.W).
//
// state | meaning
// IDLE  | no atomic in flight; decode MEM-stage atomic, check alignment / reservation
// RD    | read request for LR or the load half of an AMO
// WR    | write request for SC or the store half of an AMO
// DONE  | rd value presented; wait for the MEM stage to advance
//
// The pipeline is frozen while the unit is busy, so addr_mem, rs2_data_mem and
// amo_funct5_mem are stable for the whole sequence; the request fields are
// derived from them directly and therefore stay stable until acknowledged.
module amo_unit
  import amo_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            is_atomic_mem,
  input  logic [4:0]      amo_funct5_mem,
  input  logic [XLEN-1:0] addr_mem,
  input  logic [XLEN-1:0] rs2_data_mem,
  input  logic            mem_hold,
  input  logic            store_mem,
  input  logic            trap,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            atomic_unit_stall,
  output logic [XLEN-1:0] amo_result,
  output logic            amo_result_valid,
  output logic            amo_misaligned
);

  amo_state_t state, state_nxt;

  // result_q holds the loaded old value during RD->WR and the final rd value in DONE
  logic [XLEN-1:0] result_q, result_nxt;
  logic            resv_valid, resv_valid_nxt;
  logic [XLEN-3:0] resv_addr, resv_addr_nxt;

  logic [XLEN-3:0] word_addr;
  logic            is_lr, is_sc, misaligned, resv_match;
  logic            lr_set, sc_done, resv_clr;
  logic [XLEN-1:0] alu_out;

  assign word_addr  = addr_mem[XLEN-1:2];
  assign is_lr      = (amo_funct5_mem == AMO_LR);
  assign is_sc      = (amo_funct5_mem == AMO_SC);
  assign misaligned = (addr_mem[1:0] != 2'b00);
  assign resv_match = resv_valid && (resv_addr == word_addr);

  amo_alu #(.XLEN(XLEN)) u_alu (
    .funct5  (amo_funct5_mem),
    .old_val (result_q),
    .operand (rs2_data_mem),
    .result  (alu_out)
  );

  // State, captured data and reservation registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      result_q   <= '0;
      resv_valid <= 1'b0;
      resv_addr  <= '0;
    end else begin
      state      <= state_nxt;
      result_q   <= result_nxt;
      resv_valid <= resv_valid_nxt;
      resv_addr  <= resv_addr_nxt;
    end
  end

  // Next-state decode and memory-request / result outputs.
  always_comb begin
    state_nxt         = state;
    result_nxt        = result_q;
    dmem_req          = 1'b0;
    dmem_we           = 1'b0;
    dmem_addr         = '0;
    dmem_wdata        = '0;
    atomic_unit_stall = 1'b0;
    amo_result        = '0;
    amo_result_valid  = 1'b0;
    amo_misaligned    = 1'b0;
    lr_set            = 1'b0;
    sc_done           = 1'b0;
    case (state)
      IDLE: begin
        if (is_atomic_mem) begin
          atomic_unit_stall = 1'b1;
          if (misaligned) begin
            amo_misaligned = 1'b1;
            result_nxt     = '0;
            state_nxt      = DONE;
          end else if (is_sc) begin
            if (resv_match) begin
              state_nxt = WR;
            end else begin
              result_nxt = {{(XLEN-1){1'b0}}, 1'b1};
              sc_done    = 1'b1;
              state_nxt  = DONE;
            end
          end else begin
            state_nxt = RD;
          end
        end
      end
      RD: begin
        atomic_unit_stall = 1'b1;
        dmem_req          = 1'b1;
        dmem_addr         = {word_addr, 2'b00};
        if (dmem_ack) begin
          result_nxt = dmem_rdata;
          if (is_lr) begin
            lr_set    = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = WR;
          end
        end
      end
      WR: begin
        atomic_unit_stall = 1'b1;
        dmem_req          = 1'b1;
        dmem_we           = 1'b1;
        dmem_addr         = {word_addr, 2'b00};
        dmem_wdata        = is_sc ? rs2_data_mem : alu_out;
        if (dmem_ack) begin
          if (is_sc) begin
            result_nxt = '0;
            sc_done    = 1'b1;
          end
          state_nxt = DONE;
        end
      end
      DONE: begin
        amo_result_valid = 1'b1;
        amo_result       = result_q;
        if (!mem_hold) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reservation update: an LR in the same cycle as any clear wins.
  always_comb begin
    resv_clr       = sc_done || trap || (store_mem && resv_valid && (resv_addr == word_addr));
    resv_valid_nxt = resv_valid;
    resv_addr_nxt  = resv_addr;
    if (resv_clr) resv_valid_nxt = 1'b0;
    if (lr_set) begin
      resv_valid_nxt = 1'b1;
      resv_addr_nxt  = word_addr;
    end
  end

endmodule

// File: tb/tb_amo_unit.sv
// Directed bench for amo_unit with a small word-addressed memory model.
module tb_amo_unit;
  import amo_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        is_atomic_mem;
  logic [4:0]  amo_funct5_mem;
  logic [31:0] addr_mem, rs2_data_mem;
  logic        mem_hold, store_mem, trap;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        atomic_unit_stall;
  logic [31:0] amo_result;
  logic        amo_result_valid, amo_misaligned;

  logic [31:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [31:0] pre_addr = '0, pre_data = '0;
  logic        hold_write_ack = 1'b0;
  int          wr_cnt = 0;
  int          tests = 0;
  int          fails = 0;

  amo_unit #(.XLEN(32)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .is_atomic_mem     (is_atomic_mem),
    .amo_funct5_mem    (amo_funct5_mem),
    .addr_mem          (addr_mem),
    .rs2_data_mem      (rs2_data_mem),
    .mem_hold          (mem_hold),
    .store_mem         (store_mem),
    .trap              (trap),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_rdata        (dmem_rdata),
    .dmem_ack          (dmem_ack),
    .atomic_unit_stall (atomic_unit_stall),
    .amo_result        (amo_result),
    .amo_result_valid  (amo_result_valid),
    .amo_misaligned    (amo_misaligned)
  );

  always #5 clk = ~clk;

  // Zero-latency memory: ack in the request cycle unless writes are being held off.
  assign dmem_ack   = dmem_req && !(hold_write_ack && dmem_we);
  assign dmem_rdata = mem[dmem_addr[11:2]];

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr[11:2]] <= pre_data;
    end else if (dmem_req && dmem_we && dmem_ack) begin
      mem[dmem_addr[11:2]] <= dmem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic pulse_store(input logic [31:0] a);
    @(negedge clk);
    store_mem = 1'b1; addr_mem = a;
    @(negedge clk);
    store_mem = 1'b0;
  endtask

  task automatic pulse_trap();
    @(negedge clk);
    trap = 1'b1;
    @(negedge clk);
    trap = 1'b0;
  endtask

  // Present one atomic, count stalled cycles (bounded), sample the DONE cycle.
  task automatic run_op(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] res, output logic vld,
                        output int mis_n, output logic req_seen);
    @(negedge clk);
    is_atomic_mem = 1'b1; amo_funct5_mem = f5; addr_mem = a; rs2_data_mem = d;
    stalls = 0; mis_n = 0; req_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!atomic_unit_stall) break;
      stalls++;
      if (amo_misaligned) mis_n++;
      if (dmem_req) req_seen = 1'b1;
      @(negedge clk);
    end
    res = amo_result;
    vld = amo_result_valid;
    if (amo_misaligned) mis_n++;
    @(negedge clk);
    is_atomic_mem = 1'b0;
  endtask

  int          st, mis;
  logic [31:0] res;
  logic        vld, rq;
  int          w0;
  logic        got_wr;

  initial begin
    reset_n = 1'b0; is_atomic_mem = 1'b0; amo_funct5_mem = '0; addr_mem = '0;
    rs2_data_mem = '0; mem_hold = 1'b0; store_mem = 1'b0; trap = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_result", amo_result, 32'd0);
    check("rst_valid", {31'd0, amo_result_valid}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_stall", {31'd0, atomic_unit_stall}, 32'd0);
    check("idle_mis", {31'd0, amo_misaligned}, 32'd0);

    // AMOADD.W: 5 + 7
    preload(32'h100, 32'd5);
    run_op(AMO_ADD, 32'h100, 32'd7, st, res, vld, mis, rq);
    check("add_stalls", st, 3);
    check("add_result", res, 32'd5);
    check("add_valid", {31'd0, vld}, 32'd1);
    check("add_mem", mem[32'h100 >> 2], 32'd12);

    // LR / SC success / second SC fails
    preload(32'h200, 32'h55);
    run_op(AMO_LR, 32'h200, 32'h0, st, res, vld, mis, rq);
    check("lr_stalls", st, 2);
    check("lr_result", res, 32'h55);
    w0 = wr_cnt;
    run_op(AMO_SC, 32'h200, 32'hABCD, st, res, vld, mis, rq);
    check("sc_stalls", st, 2);
    check("sc_result", res, 32'd0);
    check("sc_mem", mem[32'h200 >> 2], 32'hABCD);
    check("sc_wrcnt", wr_cnt, w0 + 1);
    run_op(AMO_SC, 32'h200, 32'h1111, st, res, vld, mis, rq);
    check("sc2_stalls", st, 1);
    check("sc2_result", res, 32'd1);
    check("sc2_req", {31'd0, rq}, 32'd0);
    check("sc2_mem", mem[32'h200 >> 2], 32'hABCD);

    // LR, store to the reserved word, SC fails
    run_op(AMO_LR, 32'h200, 32'h0, st, res, vld, mis, rq);
    check("lr2_result", res, 32'hABCD);
    pulse_store(32'h200);
    w0 = wr_cnt;
    run_op(AMO_SC, 32'h200, 32'h2222, st, res, vld, mis, rq);
    check("sc_st_result", res, 32'd1);
    check("sc_st_wrcnt", wr_cnt, w0);

    // LR, store to a different word, SC still succeeds
    run_op(AMO_LR, 32'h200, 32'h0, st, res, vld, mis, rq);
    pulse_store(32'h204);
    run_op(AMO_SC, 32'h200, 32'h42, st, res, vld, mis, rq);
    check("sc_other_result", res, 32'd0);
    check("sc_other_mem", mem[32'h200 >> 2], 32'h42);

    // LR, trap, SC fails
    run_op(AMO_LR, 32'h200, 32'h0, st, res, vld, mis, rq);
    pulse_trap();
    w0 = wr_cnt;
    run_op(AMO_SC, 32'h200, 32'h3333, st, res, vld, mis, rq);
    check("sc_trap_result", res, 32'd1);
    check("sc_trap_wrcnt", wr_cnt, w0);

    // Signed vs unsigned min/max, logic ops, wrap, unknown funct5
    preload(32'h300, 32'hFFFF_FFFF);
    run_op(AMO_MIN, 32'h300, 32'd1, st, res, vld, mis, rq);
    check("min_mem", mem[32'h300 >> 2], 32'hFFFF_FFFF);
    check("min_result", res, 32'hFFFF_FFFF);
    preload(32'h304, 32'hFFFF_FFFF);
    run_op(AMO_MINU, 32'h304, 32'd1, st, res, vld, mis, rq);
    check("minu_mem", mem[32'h304 >> 2], 32'd1);
    preload(32'h308, 32'h8000_0000);
    run_op(AMO_MAX, 32'h308, 32'd5, st, res, vld, mis, rq);
    check("max_mem", mem[32'h308 >> 2], 32'd5);
    preload(32'h30C, 32'h8000_0000);
    run_op(AMO_MAXU, 32'h30C, 32'd5, st, res, vld, mis, rq);
    check("maxu_mem", mem[32'h30C >> 2], 32'h8000_0000);
    preload(32'h310, 32'hF0F0_1234);
    run_op(AMO_XOR, 32'h310, 32'h0FF0_00FF, st, res, vld, mis, rq);
    check("xor_mem", mem[32'h310 >> 2], 32'hFF00_12CB);
    preload(32'h314, 32'hF0F0_1234);
    run_op(AMO_AND, 32'h314, 32'h0FF0_00FF, st, res, vld, mis, rq);
    check("and_mem", mem[32'h314 >> 2], 32'h00F0_0034);
    preload(32'h318, 32'hF0F0_1234);
    run_op(AMO_OR, 32'h318, 32'h0FF0_00FF, st, res, vld, mis, rq);
    check("or_mem", mem[32'h318 >> 2], 32'hFFF0_12FF);
    preload(32'h31C, 32'hFFFF_FFFE);
    run_op(AMO_ADD, 32'h31C, 32'd3, st, res, vld, mis, rq);
    check("add_wrap_mem", mem[32'h31C >> 2], 32'd1);
    preload(32'h320, 32'h11);
    run_op(5'b00101, 32'h320, 32'hDEAD, st, res, vld, mis, rq);
    check("unk_mem", mem[32'h320 >> 2], 32'hDEAD);
    check("unk_result", res, 32'h11);

    // Misaligned AMO
    run_op(AMO_ADD, 32'h102, 32'd1, st, res, vld, mis, rq);
    check("mis_stalls", st, 1);
    check("mis_pulses", mis, 1);
    check("mis_req", {31'd0, rq}, 32'd0);
    check("mis_result", res, 32'd0);
    check("mis_mem", mem[32'h100 >> 2], 32'd12);

    // Reset while a write is withheld
    preload(32'h400, 32'h77);
    run_op(AMO_LR, 32'h400, 32'h0, st, res, vld, mis, rq);
    check("lr4_result", res, 32'h77);
    hold_write_ack = 1'b1;
    @(negedge clk);
    is_atomic_mem = 1'b1; amo_funct5_mem = AMO_SWAP; addr_mem = 32'h400; rs2_data_mem = 32'h99;
    got_wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (dmem_req && dmem_we) begin
        got_wr = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_wr", {31'd0, got_wr}, 32'd1);
    is_atomic_mem = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rstwr_req", {31'd0, dmem_req}, 32'd0);
    check("rstwr_we", {31'd0, dmem_we}, 32'd0);
    check("rstwr_addr", dmem_addr, 32'd0);
    check("rstwr_wdata", dmem_wdata, 32'd0);
    hold_write_ack = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rstwr_state", 32'(dut.state), 32'(IDLE));
    check("rstwr_mem", mem[32'h400 >> 2], 32'h77);
    run_op(AMO_SC, 32'h400, 32'h5A, st, res, vld, mis, rq);
    check("rstwr_sc_result", res, 32'd1);
    check("rstwr_sc_mem", mem[32'h400 >> 2], 32'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
